// File: rtl/hazard_pkg.sv
// Shared constants for the ID/EX control stage: control-vector layout,
// bubble encoding and the per-edge action enumeration.
package hazard_pkg;

    localparam int CTRL_W       = 48;
    localparam int ALUOP_LSB    = 0;
    localparam int ALUOP_MSB    = 4;
    localparam int REGDST_LSB   = 5;
    localparam int REGDST_MSB   = 6;
    localparam int REGWRITE_BIT = 8;
    localparam int MEMREAD_BIT  = 9;

    localparam logic [CTRL_W-1:0] NOP_CTRL  = {43'b0, 5'b11011};
    localparam logic [CTRL_W-1:0] KEEP_MASK = 48'h0000_0000_0060;

    // What the D2 register does on a non-reset edge, in priority order.
    typedef enum logic [1:0] {
        ACT_FLUSH   = 2'd0,
        ACT_HOLD    = 2'd1,
        ACT_BUBBLE  = 2'd2,
        ACT_ADVANCE = 2'd3
    } d2_action_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: flags when the instruction in ID reads
// a register that the load currently in EX has not yet produced.
module hazard_detect #(
    parameter int NUM_SRC = 2
) (
    input  logic                 i_d2_memread,
    input  logic [4:0]           i_d2_write_reg,
    input  logic [NUM_SRC*5-1:0] i_d1_src,
    input  logic [NUM_SRC-1:0]   i_d1_uses_src,
    output logic                 o_load_use
);

    logic w_any_match;

    always_comb begin
        w_any_match = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i_d1_uses_src[i] && (i_d1_src[5*i +: 5] == i_d2_write_reg)) begin
                w_any_match = 1'b1;
            end
        end
    end

    // Register 0 is hardwired, so a load targeting it can never hazard.
    assign o_load_use = i_d2_memread && (i_d2_write_reg != 5'd0) && w_any_match;

endmodule

// File: rtl/hazard_ctrl_stage.sv
// ID/EX control register with built-in load-use bubbling, multi-cycle EX hold,
// branch flush, fetch-enable generation and a saturating stall counter.
module hazard_ctrl_stage
    import hazard_pkg::*;
#(
    parameter int                CTRL_W      = hazard_pkg::CTRL_W,
    parameter logic [CTRL_W-1:0] NOP_CTRL    = hazard_pkg::NOP_CTRL,
    parameter logic [CTRL_W-1:0] KEEP_MASK   = hazard_pkg::KEEP_MASK,
    parameter int                MEMREAD_BIT = hazard_pkg::MEMREAD_BIT,
    parameter int                NUM_SRC     = 2,
    parameter int                HOLD_W      = 3,
    parameter int                PERF_W      = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [CTRL_W-1:0]    D1_Ctrl,
    input  logic [NUM_SRC*5-1:0] D1_Src,
    input  logic [NUM_SRC-1:0]   D1_UsesSrc,
    input  logic [4:0]           D1_WriteReg,
    input  logic [HOLD_W-1:0]    D1_HoldCycles,
    input  logic                 Flush,
    output logic [CTRL_W-1:0]    D2_Ctrl,
    output logic [4:0]           D2_WriteReg,
    output logic                 D2_Hold,
    output logic                 PCWrite,
    output logic                 IFIDWrite,
    output logic [PERF_W-1:0]    StallCount
);

    logic [CTRL_W-1:0] r_d2_ctrl;
    logic [4:0]        r_d2_write_reg;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [PERF_W-1:0] r_stall_cnt;

    logic              w_load_use;
    logic              w_busy;
    logic              w_fetch_en;
    logic [CTRL_W-1:0] w_bubble_ctrl;
    d2_action_e        w_action;

    hazard_detect #(
        .NUM_SRC (NUM_SRC)
    ) u_detect (
        .i_d2_memread   (r_d2_ctrl[MEMREAD_BIT]),
        .i_d2_write_reg (r_d2_write_reg),
        .i_d1_src       (D1_Src),
        .i_d1_uses_src  (D1_UsesSrc),
        .o_load_use     (w_load_use)
    );

    assign w_busy = (r_hold_cnt != '0);

    // Flush re-opens fetch even while stalled so the branch target gets loaded.
    assign w_fetch_en = ~(w_busy | w_load_use) | Flush;

    // A bubble still carries the ID instruction's KEEP_MASK fields (RegDst).
    assign w_bubble_ctrl = (NOP_CTRL & ~KEEP_MASK) | (D1_Ctrl & KEEP_MASK);

    always_comb begin
        w_action = ACT_ADVANCE;
        if (Flush) begin
            w_action = ACT_FLUSH;
        end else if (w_busy) begin
            w_action = ACT_HOLD;
        end else if (w_load_use) begin
            w_action = ACT_BUBBLE;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_d2_ctrl      <= NOP_CTRL;
            r_d2_write_reg <= 5'd0;
            r_hold_cnt     <= '0;
            r_stall_cnt    <= '0;
        end else begin
            if (!w_fetch_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            case (w_action)
                ACT_FLUSH: begin
                    r_d2_ctrl      <= NOP_CTRL;
                    r_d2_write_reg <= 5'd0;
                    r_hold_cnt     <= '0;
                end
                ACT_HOLD: begin
                    r_d2_ctrl      <= r_d2_ctrl;
                    r_d2_write_reg <= r_d2_write_reg;
                    r_hold_cnt     <= r_hold_cnt - 1'b1;
                end
                ACT_BUBBLE: begin
                    r_d2_ctrl      <= w_bubble_ctrl;
                    r_d2_write_reg <= 5'd0;
                    r_hold_cnt     <= r_hold_cnt;
                end
                default: begin
                    r_d2_ctrl      <= D1_Ctrl;
                    r_d2_write_reg <= D1_WriteReg;
                    r_hold_cnt     <= D1_HoldCycles;
                end
            endcase
        end
    end

    assign D2_Ctrl     = r_d2_ctrl;
    assign D2_WriteReg = r_d2_write_reg;
    assign D2_Hold     = w_busy;
    assign PCWrite     = w_fetch_en;
    assign IFIDWrite   = w_fetch_en;
    assign StallCount  = r_stall_cnt;

endmodule
